// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
//
// Elastic pipeline register: a DEPTH-entry valid/ready circular buffer carrying
// an opaque DATA_W-bit payload between a producer and a consumer stage.
// There is no same-cycle pass-through, and i_ready depends only on
// registered occupancy.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst_n        synchronous reset, active-low (clears pointers, count and mem)
//   flush        discard all buffered entries this cycle (beats enq/deq)
//   i_valid      producer has payload
//   i_ready      buffer can accept payload (cnt != DEPTH)
//   i_data       producer payload
//   o_valid      head entry valid (cnt != 0)
//   o_ready      consumer accepts head
//   o_data       head entry payload, mem[rd_ptr]
//   o_data_next  head payload that will be visible after the coming edge
//   count        current occupancy, 0..DEPTH
//
// Optional build macro ELASTIC_PIPE_REG_STATS_EN adds these ports:
//   stall_cycles     saturating count of cycles with o_valid && !o_ready
//   flushed_entries  saturating sum of entries discarded by flush
// -----------------------------------------------------------------------------
module elastic_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [DATA_W-1:0] o_data_next,
    output logic [CNT_W-1:0]  count
`ifdef ELASTIC_PIPE_REG_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flushed_entries
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              enq;
    logic              deq;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [PTR_W-1:0]  wr_ptr_inc;

    // Explicit wrap compare so non-power-of-2 depths work.
    assign rd_ptr_inc = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    assign wr_ptr_inc = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;

    assign i_ready = (cnt_q != CNT_W'(DEPTH));
    assign o_valid = (cnt_q != '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign count   = cnt_q;

    assign enq = i_valid && i_ready;
    assign deq = o_valid && o_ready;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            // mem is deliberately left intact; only the bookkeeping is cleared.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = wr_ptr_inc;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_inc;
            end
            if (enq && !deq) begin
                cnt_d = cnt_q + 1'b1;
            end else if (deq && !enq) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Look-ahead head so a downstream SRAM can be addressed a cycle early.
    always_comb begin
        o_data_next = o_data;
        if (rst_n && !flush) begin
            if (deq && (cnt_q >= CNT_W'(2))) begin
                o_data_next = mem_q[rd_ptr_inc];
            end else if (enq && ((cnt_q == '0) || (deq && (cnt_q == CNT_W'(1))))) begin
                o_data_next = i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ELASTIC_PIPE_REG_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flushed_q, flushed_d;
    logic [32:0] flushed_sum;

    always_comb begin
        stall_d     = stall_q;
        flushed_d   = flushed_q;
        flushed_sum = {1'b0, flushed_q} + 33'(cnt_q);
        if (o_valid && !o_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        // Counts buffered entries only; an enq dropped by the flush is not included.
        if (flush) begin
            flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            stall_q   <= stall_d;
            flushed_q <= flushed_d;
        end
    end

    assign stall_cycles    = stall_q;
    assign flushed_entries = flushed_q;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_reg
//
// Drives one shared stimulus stream into two instances (DEPTH=2 and DEPTH=3)
// and checks both against a queue-based reference model of an ideal bounded
// FIFO with flush.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_ready;

    logic        i_ready_a, i_ready_b;
    logic        o_valid_a, o_valid_b;
    logic [31:0] o_data_a, o_data_b;
    logic [31:0] o_data_next_a, o_data_next_b;
    logic [1:0]  count_a, count_b;
`ifdef ELASTIC_PIPE_REG_STATS_EN
    logic [31:0] stall_a, stall_b, flushed_a, flushed_b;
    int unsigned m_stall [2];
    int unsigned m_flushed [2];
`endif

    always #5 clk = ~clk;

    elastic_pipe_reg #(.DATA_W(32), .DEPTH(2)) u_dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .i_valid         (i_valid),
        .i_ready         (i_ready_a),
        .i_data          (i_data),
        .o_valid         (o_valid_a),
        .o_ready         (o_ready),
        .o_data          (o_data_a),
        .o_data_next     (o_data_next_a),
        .count           (count_a)
`ifdef ELASTIC_PIPE_REG_STATS_EN
        ,
        .stall_cycles    (stall_a),
        .flushed_entries (flushed_a)
`endif
    );

    elastic_pipe_reg #(.DATA_W(32), .DEPTH(3)) u_dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .i_valid         (i_valid),
        .i_ready         (i_ready_b),
        .i_data          (i_data),
        .o_valid         (o_valid_b),
        .o_ready         (o_ready),
        .o_data          (o_data_b),
        .o_data_next     (o_data_next_b),
        .count           (count_b)
`ifdef ELASTIC_PIPE_REG_STATS_EN
        ,
        .stall_cycles    (stall_b),
        .flushed_entries (flushed_b)
`endif
    );

    // Reference model: one queue per instance, head at index 0.
    logic [31:0] mq [2][$];
    int unsigned depth [2] = '{2, 3};
    bit          fresh [2];   // no enq since reset: mem is all zero
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s (DEPTH=%0d): observed %h expected %h", tag, depth[k], obs, exp);
        end
    endtask

    function automatic logic [31:0] get_out(input int k, input int which);
        case (which)
            0: get_out = (k == 0) ? 32'(count_a) : 32'(count_b);
            1: get_out = (k == 0) ? 32'(i_ready_a) : 32'(i_ready_b);
            2: get_out = (k == 0) ? 32'(o_valid_a) : 32'(o_valid_b);
            3: get_out = (k == 0) ? o_data_a : o_data_b;
            default: get_out = (k == 0) ? o_data_next_a : o_data_next_b;
        endcase
    endfunction

    task automatic check_state(input int k);
        int sz;
        sz = mq[k].size();
        chk("count", k, get_out(k, 0), 32'(sz));
        chk("i_ready", k, get_out(k, 1), 32'(sz < int'(depth[k])));
        chk("o_valid", k, get_out(k, 2), 32'(sz > 0));
        if (sz > 0) begin
            chk("o_data", k, get_out(k, 3), mq[k][0]);
        end else if (fresh[k]) begin
            chk("o_data_rst", k, get_out(k, 3), 32'h0);
        end
`ifdef ELASTIC_PIPE_REG_STATS_EN
        chk("stall_cycles", k, (k == 0) ? stall_a : stall_b, m_stall[k]);
        chk("flushed_entries", k, (k == 0) ? flushed_a : flushed_b, m_flushed[k]);
`endif
    endtask

    // One clock cycle: apply inputs, check look-ahead before the edge,
    // advance the model at the edge, then check registered outputs.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        logic [31:0] nxt [$];
        int          sz;
        bit          enq, deq;
        i_valid = v;
        i_data  = d;
        o_ready = r;
        flush   = f;
        #2;
        for (int k = 0; k < 2; k++) begin
            sz  = mq[k].size();
            enq = v && (sz < int'(depth[k]));
            deq = r && (sz > 0);
            nxt = mq[k];
            if (deq) void'(nxt.pop_front());
            if (enq) nxt.push_back(d);
            if (f) begin
                if (sz > 0) chk("o_data_next_flush", k, get_out(k, 4), mq[k][0]);
            end else if (nxt.size() > 0) begin
                chk("o_data_next", k, get_out(k, 4), nxt[0]);
            end else if (sz > 0) begin
                chk("o_data_next_drain", k, get_out(k, 4), mq[k][0]);
            end
`ifdef ELASTIC_PIPE_REG_STATS_EN
            if (sz > 0 && !r) m_stall[k]++;
            if (f) m_flushed[k] += sz;
`endif
            if (f) begin
                mq[k] = {};
            end else begin
                mq[k] = nxt;
                if (enq) fresh[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_state(k);
    endtask

    // Reset asserted with flush and a pending push to show reset wins.
    task automatic do_reset();
        rst_n   = 1'b0;
        flush   = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'hDEAD_BEEF;
        o_ready = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            if (mq[k].size() > 0) chk("o_data_next_rst", k, get_out(k, 4), mq[k][0]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mq[k]    = {};
            fresh[k] = 1'b1;
`ifdef ELASTIC_PIPE_REG_STATS_EN
            m_stall[k]   = 0;
            m_flushed[k] = 0;
`endif
            check_state(k);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        o_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Fill with o_ready low, then try to push into a full buffer.
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        // Drain for three cycles.
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Continuous streaming 1..100.
        for (int i = 1; i <= 100; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Look-ahead cases: two entries with a pop, then one entry with pop+push.
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b0);
        step(1'b1, 32'h44, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Flush while holding entries, with a push that must be dropped.
        step(1'b1, 32'h66, 1'b0, 1'b0);
        step(1'b1, 32'h55, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h77, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Wrap-around rounds: two pushes then two pops, reset mid-way.
        for (int rnd = 0; rnd < 10; rnd++) begin
            step(1'b1, 32'h100 + 32'(2 * rnd), 1'b0, 1'b0);
            step(1'b1, 32'h101 + 32'(2 * rnd), 1'b0, 1'b0);
            if (rnd == 5) do_reset();
            step(1'b0, 32'h0, 1'b1, 1'b0);
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
